// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-scan input
// snapshot, leading-zero blanking, per-digit blink and a dead cycle per slot.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_SCANS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    scan_done
);

    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCNT_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_SCANS - 1);

    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'b0000001;
            5'd1:    s = 7'b1001111;
            5'd2:    s = 7'b0010010;
            5'd3:    s = 7'b0000110;
            5'd4:    s = 7'b1001100;
            5'd5:    s = 7'b0100100;
            5'd6:    s = 7'b0100000;
            5'd7:    s = 7'b0001111;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0000100;
            5'd10:   s = 7'b0001000;
            5'd11:   s = 7'b1100000;
            5'd12:   s = 7'b0110001;
            5'd13:   s = 7'b1000010;
            5'd14:   s = 7'b0110000;
            5'd15:   s = 7'b0111000;
            5'd17:   s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic                    bphase_q, bphase_d;
    logic [5*NUM_DIGITS-1:0] snap_codes_q, snap_codes_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic                    scan_done_q, scan_done_d;

    logic                    cnt_wrap;
    logic                    scan_end;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [4:0]              sel_code;
    logic                    sel_dp;
    logic                    sel_blink;
    logic                    sel_lz;

    always_comb begin
        cnt_wrap     = (cnt_q == CNT_MAX);
        scan_end     = cnt_wrap && (idx_q == IDX_MAX);
        cnt_d        = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        bcnt_d       = bcnt_q;
        bphase_d     = bphase_q;
        snap_codes_d = snap_codes_q;
        snap_dp_d    = snap_dp_q;
        snap_blink_d = snap_blink_q;
        snap_lz_d    = snap_lz_q;
        scan_done_d  = scan_end;

        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
        // Inputs are only ever sampled at the scan boundary
        if (scan_end) begin
            snap_codes_d = digits;
            snap_dp_d    = dp;
            snap_blink_d = blink;
            snap_lz_d    = lz_blank;
            if (bcnt_q == BCNT_MAX) begin
                bcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                bcnt_d   = bcnt_q + BCNT_W'(1);
            end
        end

        // A run of zero codes from the most significant digit down; digit 0 is exempt
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (snap_codes_q[5*i +: 5] == 5'd0);
            lz_mask[i] = snap_lz_q && zero_run && (i != 0);
        end

        sel_code  = 5'd16;
        sel_dp    = 1'b0;
        sel_blink = 1'b0;
        sel_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_code  = snap_codes_q[5*i +: 5];
                sel_dp    = snap_dp_q[i];
                sel_blink = snap_blink_q[i];
                sel_lz    = lz_mask[i];
            end
        end

        an_d   = '1;
        seg_d  = 7'b1111111;
        dp_n_d = 1'b1;
        if (cnt_q != '0) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IDX_W'(i));
            end
            if (sel_blink && bphase_q) begin
                seg_d  = 7'b1111111;
                dp_n_d = 1'b1;
            end else if (sel_lz) begin
                seg_d  = 7'b1111111;
                dp_n_d = ~sel_dp;
            end else begin
                seg_d  = decode(sel_code);
                dp_n_d = ~sel_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            bcnt_q       <= '0;
            bphase_q     <= 1'b0;
            snap_codes_q <= {NUM_DIGITS{5'd16}};
            snap_dp_q    <= '0;
            snap_blink_q <= '0;
            snap_lz_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'b1111111;
            dp_n_q       <= 1'b1;
            scan_done_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            bcnt_q       <= bcnt_d;
            bphase_q     <= bphase_d;
            snap_codes_q <= snap_codes_d;
            snap_dp_q    <= snap_dp_d;
            snap_blink_q <= snap_blink_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            scan_done_q  <= scan_done_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: a 4-digit scanner for ordering, snapshot,
// LZ, dp, blink and reset, plus a 1-digit instance for the symbol decode table.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;

    logic [19:0] digits4;
    logic [3:0]  dp4, blink4;
    logic        lz4;
    logic [3:0]  an4;
    logic [6:0]  seg4;
    logic        dpn4, sd4;

    logic [4:0]  digits1;
    logic [0:0]  dp1, blink1;
    logic        lz1;
    logic [0:0]  an1;
    logic [6:0]  seg1;
    logic        dpn1, sd1;

    int total = 0;
    int bad   = 0;

    seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_SCANS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .digits(digits4), .dp(dp4), .blink(blink4),
        .lz_blank(lz4), .an(an4), .seg(seg4), .dp_n(dpn4), .scan_done(sd4)
    );

    seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2), .BLINK_SCANS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .digits(digits1), .dp(dp1), .blink(blink1),
        .lz_blank(lz1), .an(an1), .seg(seg1), .dp_n(dpn1), .scan_done(sd1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] code;
        logic       dp;
        logic [6:0] seg;
        logic       dp_n;
    } vec_t;

    vec_t tbl[32];

    // Segment patterns {a..g} for the 4-digit scenes, digit3 at the top
    localparam logic [27:0] S3210  = {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
    localparam logic [27:0] S3210B = {7'b0000110, 7'b0010010, 7'b1001111, 7'b1111111};
    localparam logic [27:0] S1234  = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    localparam logic [27:0] S5678  = {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
    localparam logic [27:0] SLZ40  = {7'b1111111, 7'b1111111, 7'b1001100, 7'b0000001};
    localparam logic [27:0] SZERO  = {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001};
    localparam logic [27:0] SDASH  = {7'b1111111, 7'b1111110, 7'b0000001, 7'b0000001};
    localparam logic [27:0] SBLANK = {4{7'b1111111}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks 4-digit output slots j0..j1 of one scan; call with the bench sitting
    // on the negedge where scan_done (or reset release) marks the scan start.
    task automatic check_slots(input string tag, input int j0, input int j1,
                               input logic [27:0] eseg, input logic [3:0] edpn);
        for (int j = j0; j <= j1; j++) begin
            int         d;
            int         c;
            logic [3:0] ean;
            logic [6:0] es;
            logic       ed;
            @(posedge clk);
            @(negedge clk);
            d = j / 4;
            c = j % 4;
            if (c == 0) begin
                ean = 4'hF;
                es  = 7'h7F;
                ed  = 1'b1;
            end else begin
                ean = ~(4'b0001 << d);
                es  = eseg[7*d +: 7];
                ed  = edpn[d];
            end
            chk($sformatf("%s an j=%0d", tag, j), 32'(an4), 32'(ean));
            chk($sformatf("%s seg j=%0d", tag, j), 32'(seg4), 32'(es));
            chk($sformatf("%s dp_n j=%0d", tag, j), 32'(dpn4), 32'(ed));
            chk($sformatf("%s scan_done j=%0d", tag, j), 32'(sd4), 32'(j == 15));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " an4"}, 32'(an4), 32'hF);
        chk({tag, " seg4"}, 32'(seg4), 32'h7F);
        chk({tag, " dp_n4"}, 32'(dpn4), 32'd1);
        chk({tag, " scan_done4"}, 32'(sd4), 32'd0);
        chk({tag, " an1"}, 32'(an1), 32'd1);
        chk({tag, " seg1"}, 32'(seg1), 32'h7F);
        chk({tag, " dp_n1"}, 32'(dpn1), 32'd1);
        chk({tag, " scan_done1"}, 32'(sd1), 32'd0);
    endtask

    initial begin
        // Decode table: dp follows code bit 0; codes 18..31 are blank
        tbl[0]  = '{5'd0,  1'b0, 7'b0000001, 1'b1};
        tbl[1]  = '{5'd1,  1'b1, 7'b1001111, 1'b0};
        tbl[2]  = '{5'd2,  1'b0, 7'b0010010, 1'b1};
        tbl[3]  = '{5'd3,  1'b1, 7'b0000110, 1'b0};
        tbl[4]  = '{5'd4,  1'b0, 7'b1001100, 1'b1};
        tbl[5]  = '{5'd5,  1'b1, 7'b0100100, 1'b0};
        tbl[6]  = '{5'd6,  1'b0, 7'b0100000, 1'b1};
        tbl[7]  = '{5'd7,  1'b1, 7'b0001111, 1'b0};
        tbl[8]  = '{5'd8,  1'b0, 7'b0000000, 1'b1};
        tbl[9]  = '{5'd9,  1'b1, 7'b0000100, 1'b0};
        tbl[10] = '{5'd10, 1'b0, 7'b0001000, 1'b1};
        tbl[11] = '{5'd11, 1'b1, 7'b1100000, 1'b0};
        tbl[12] = '{5'd12, 1'b0, 7'b0110001, 1'b1};
        tbl[13] = '{5'd13, 1'b1, 7'b1000010, 1'b0};
        tbl[14] = '{5'd14, 1'b0, 7'b0110000, 1'b1};
        tbl[15] = '{5'd15, 1'b1, 7'b0111000, 1'b0};
        tbl[16] = '{5'd16, 1'b0, 7'b1111111, 1'b1};
        tbl[17] = '{5'd17, 1'b1, 7'b1111110, 1'b0};
        tbl[18] = '{5'd18, 1'b0, 7'b1111111, 1'b1};
        tbl[19] = '{5'd19, 1'b1, 7'b1111111, 1'b0};
        tbl[20] = '{5'd20, 1'b0, 7'b1111111, 1'b1};
        tbl[21] = '{5'd21, 1'b1, 7'b1111111, 1'b0};
        tbl[22] = '{5'd22, 1'b0, 7'b1111111, 1'b1};
        tbl[23] = '{5'd23, 1'b1, 7'b1111111, 1'b0};
        tbl[24] = '{5'd24, 1'b0, 7'b1111111, 1'b1};
        tbl[25] = '{5'd25, 1'b1, 7'b1111111, 1'b0};
        tbl[26] = '{5'd26, 1'b0, 7'b1111111, 1'b1};
        tbl[27] = '{5'd27, 1'b1, 7'b1111111, 1'b0};
        tbl[28] = '{5'd28, 1'b0, 7'b1111111, 1'b1};
        tbl[29] = '{5'd29, 1'b1, 7'b1111111, 1'b0};
        tbl[30] = '{5'd30, 1'b0, 7'b1111111, 1'b1};
        tbl[31] = '{5'd31, 1'b1, 7'b1111111, 1'b0};

        rst_n   = 1'b0;
        digits4 = {5'd3, 5'd2, 5'd1, 5'd0};
        dp4     = 4'b0000;
        blink4  = 4'b0000;
        lz4     = 1'b0;
        digits1 = 5'd16;
        dp1     = 1'b0;
        blink1  = 1'b0;
        lz1     = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Inputs for scan N are applied during scan N-2 or N-1, before the snapshot
        check_slots("scan0_blank", 0, 15, SBLANK, 4'b1111);
        digits4 = {5'd1, 5'd2, 5'd3, 5'd4};
        check_slots("scan1_3210", 0, 15, S3210, 4'b1111);
        check_slots("scan2_1234a", 0, 7, S1234, 4'b1111);
        digits4 = {5'd5, 5'd6, 5'd7, 5'd8};
        check_slots("scan2_1234b", 8, 15, S1234, 4'b1111);
        dp4 = 4'b0101;
        check_slots("scan3_5678", 0, 15, S5678, 4'b1111);
        digits4 = {5'd0, 5'd0, 5'd4, 5'd0};
        dp4     = 4'b1000;
        lz4     = 1'b1;
        check_slots("scan4_dp", 0, 15, S5678, 4'b1010);
        digits4 = {5'd0, 5'd0, 5'd0, 5'd0};
        dp4     = 4'b0000;
        check_slots("scan5_lz40", 0, 15, SLZ40, 4'b0111);
        digits4 = {5'd0, 5'd17, 5'd0, 5'd0};
        check_slots("scan6_zero", 0, 15, SZERO, 4'b1111);
        check_slots("scan7_dash", 0, 15, SDASH, 4'b1111);
        check_slots("scan8_pre", 0, 5, SDASH, 4'b1111);

        // Asynchronous reset in the middle of a lit slot
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        digits4 = {5'd3, 5'd2, 5'd1, 5'd0};
        dp4     = 4'b0011;
        blink4  = 4'b0001;
        lz4     = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;

        check_slots("b_scan0_blank", 0, 15, SBLANK, 4'b1111);
        check_slots("b_scan1_on", 0, 15, S3210, 4'b1100);
        check_slots("b_scan2_off", 0, 15, S3210B, 4'b1101);
        check_slots("b_scan3_off", 0, 15, S3210B, 4'b1101);
        check_slots("b_scan4_on", 0, 15, S3210, 4'b1100);
        check_slots("b_scan5_on", 0, 15, S3210, 4'b1100);
        check_slots("b_scan6_off", 0, 15, S3210B, 4'b1101);

        // Single-digit decode sweep with LZ enabled (digit 0 is never blanked)
        begin
            int n = 0;
            while (sd1 !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("sd1_sync", 32'(sd1), 32'd1);
        end
        for (int v = 0; v < 32; v++) begin
            digits1 = tbl[v].code;
            dp1     = tbl[v].dp;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("dec dead an code=%0d", v), 32'(an1), 32'd1);
            chk($sformatf("dec dead seg code=%0d", v), 32'(seg1), 32'h7F);
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
            end
            chk($sformatf("dec an code=%0d", v), 32'(an1), 32'd0);
            chk($sformatf("dec seg code=%0d", v), 32'(seg1), 32'(tbl[v].seg));
            chk($sformatf("dec dp_n code=%0d", v), 32'(dpn1), 32'(tbl[v].dp_n));
            chk($sformatf("dec scan_done code=%0d", v), 32'(sd1), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed vector of 5-bit symbol codes, one per digit, and scans them onto the shared cathode bus. The symbol set is hex 0–F, blank and dash. Per-scan input snapshotting, leading-zero blanking, per-digit blink, decimal points and an inter-digit dead cycle are built in. It sits between the game/score logic and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (legal 1..8).
- REFRESH_DIV, 100000, clock cycles each digit is selected, dead cycle included (legal ≥ 2).
- BLINK_SCANS, 64, full scans per blink half-period (legal ≥ 1).
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- digits  in  5*NUM_DIGITS  symbol codes; digit i at [5i+4:5i]; digit 0 is least significant (rightmost).
- dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blink  in  NUM_DIGITS  per-digit blink enable.
- lz_blank  in  1  leading-zero blanking enable.
- an  out  NUM_DIGITS  anode select, active-low one-hot, or all-1 when off.
- seg  out  7  cathodes {a,b,c,d,e,f,g} = seg[6:0], active-low.
- dp_n  out  1  decimal point cathode, active-low.
- scan_done  out  1  one-cycle pulse after each full scan.

## Operation
- Symbol codes:
  - 0–9 and A,b,C,d,E,F (codes 0–15) use the standard patterns (0 → 0000001, 1 → 1001111, 8 → 0000000, F → 0111000).
  - 16 = blank (1111111); 17 = dash (1111110).
  - 18–31 = blank.
- State:
  - cnt: 0..REFRESH_DIV-1, increments every cycle and wraps.
  - idx: 0..NUM_DIGITS-1, increments when cnt wraps; wraps from NUM_DIGITS-1 to 0.
  - snap: registered copy of digits/dp/blink/lz_blank.
  - bcnt: 0..BLINK_SCANS-1 scan counter.
  - bphase: 1 bit.
- Snapshot: snap loads on the edge where cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1, i.e. the same edge idx wraps to 0. Inputs are sampled only there, so input changes mid-scan never appear until the next scan.
- Blink: on that same edge bcnt increments. When bcnt wraps, bphase toggles. While bphase==1, every digit with its snap blink bit set shows blank with dp off.
- Leading-zero blanking: when snap lz_blank==1, digit i (i ≥ 1) is blanked if every snap code at positions i..NUM_DIGITS-1 equals 0.
  - Digit 0 is never blanked by this rule.
  - Any nonzero code, including 16/17, stops the run.
  - Blanked digits still honour dp.
- Dead cycle: when cnt==0, the driver emits an all-1, seg all-1 and dp_n=1, to suppress ghosting.
- Selected digit: when cnt ≥ 1, the driver emits an with bit idx low and the decoded snap code with blink/LZ rules applied. dp_n = ~snap dp[idx] unless blanked by blink.
- Priority: blink blanking > LZ blanking > decode.

## Timing
- All outputs are registered. Outputs in cycle k+1 are a function of cnt/idx/snap/bphase in cycle k (one-cycle latency).
- Reset values (async, immediate on rst_n low):
  - an = all-1, seg = 1111111, dp_n = 1, scan_done = 0.
  - cnt = 0, idx = 0, bcnt = 0, bphase = 0.
  - snap codes = 16 (blank), snap dp/blink/lz_blank = 0.
- After rst_n rises, the first snapshot is taken after NUM_DIGITS*REFRESH_DIV cycles. Until then the display stays blank with anodes cycling.
- Full scan period = NUM_DIGITS*REFRESH_DIV cycles. Each digit's anode is low for REFRESH_DIV-1 consecutive cycles, preceded by 1 all-off cycle.
- scan_done is high for exactly one cycle, the cycle after the snapshot edge, once per scan.
- Blink half-period = BLINK_SCANS scans.
- NUM_DIGITS=1: idx is constant 0; snapshot and scan_done occur on every cnt wrap.
- Reset mid-scan: everything returns to reset values within the same cycle; no partial snapshot survives.

## Test plan
- Reset: hold rst_n low mid-scan -> an=1111, seg=1111111, dp_n=1, scan_done=0 asynchronously; after release, blank until first scan_done.
- Decode sweep (NUM_DIGITS=1, REFRESH_DIV=2): drive codes 0..31 one per scan -> seg matches the table. 16 and 18–31 give 1111111; 17 gives 1111110.
- Scan order (NUM_DIGITS=4, REFRESH_DIV=4): digits=codes {3,2,1,0} -> per 4-cycle slot, 1 dead cycle then an=1110/1101/1011/0111 for 3 cycles each; scan_done every 16 cycles.
- Snapshot: change digits mid-scan from 1234 to 5678 -> 1234 completes the current scan; 5678 appears starting with the digit-0 slot after the next scan_done.
- Leading zeros: lz_blank=1, digits 0,0,4,0 (MSB first), dp[3]=1 -> digit3 blank with dp lit, digit2 blank, digits 1,0 show 4,0; all zeros shows only digit0 "0".
- Blink (BLINK_SCANS=2): blink=0001 -> digit0 visible for 2 scans, blank for 2 scans, repeating; other digits unaffected.
